// File: rtl/ace_ccu_pkg.sv
// Shared constants for the ACE CCU snoop-response path: CRRESP bit positions and FSM states.
package ace_ccu_pkg;

  localparam int unsigned CrRespW        = 5;
  localparam int unsigned CrDataTransfer = 0;
  localparam int unsigned CrError        = 1;
  localparam int unsigned CrPassDirty    = 2;
  localparam int unsigned CrIsShared     = 3;
  localparam int unsigned CrWasUnique    = 4;

  typedef enum logic [1:0] {
    Idle    = 2'd0,
    Collect = 2'd1,
    Resp    = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO (common-cells fifo_v3 style, registered head, no fall-through).
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH-1:0] LastPtr = ADDR_DEPTH'(DEPTH - 1);

  dtype                  mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] read_ptr_q, write_ptr_q;
  logic [ADDR_DEPTH:0]   status_cnt_q;
  logic                  do_push, do_pop;

  assign full_o  = (status_cnt_q == (ADDR_DEPTH + 1)'(DEPTH));
  assign empty_o = (status_cnt_q == '0);
  assign usage_o = status_cnt_q[ADDR_DEPTH-1:0];
  assign data_o  = mem_q[read_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      read_ptr_q   <= '0;
      write_ptr_q  <= '0;
      status_cnt_q <= '0;
    end else if (flush_i) begin
      read_ptr_q   <= '0;
      write_ptr_q  <= '0;
      status_cnt_q <= '0;
    end else begin
      if (do_push) write_ptr_q <= next_ptr(write_ptr_q);
      if (do_pop)  read_ptr_q  <= next_ptr(read_ptr_q);
      case ({do_push, do_pop})
        2'b10:   status_cnt_q <= status_cnt_q + 1'b1;
        2'b01:   status_cnt_q <= status_cnt_q - 1'b1;
        default: status_cnt_q <= status_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[write_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ace_ccu_snoop_resp.sv
// Collects per-master snoop CR responses for each queued ctrl entry and emits one merged CRRESP.
// Optional collect timeout is enabled by defining ACE_CCU_SNOOP_RESP_TIMEOUT_EN.
module ace_ccu_snoop_resp
  import ace_ccu_pkg::*;
#(
  parameter int unsigned NumInp        = 2,
  parameter int unsigned NumOup        = 4,
  parameter int unsigned CtrlDepth     = 4,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned IdxW         = (NumInp > 1) ? $clog2(NumInp) : 1,
  parameter type         ctrl_t        = logic [NumOup+IdxW-1:0]
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            ctrl_valid_i,
  output logic                            ctrl_ready_o,
  input  ctrl_t                           ctrl_i,
  input  logic [NumOup-1:0]               cr_valids_i,
  output logic [NumOup-1:0]               cr_readies_o,
  input  logic [NumOup-1:0][CrRespW-1:0]  cr_resps_i,
  output logic                            cr_valid_o,
  input  logic                            cr_ready_i,
  output logic [CrRespW-1:0]              cr_resp_o,
  output logic [IdxW-1:0]                 cr_idx_o,
  output logic                            timeout_o
);

  localparam int unsigned CtrlW  = NumOup + IdxW;
  localparam int unsigned UsageW = (CtrlDepth > 1) ? $clog2(CtrlDepth) : 1;

  // Every handshake (ctrl, per-master CR, merged CR) transfers on a rising edge where
  // valid && ready; a valid, once raised, holds its payload stable until accepted.
  logic [CtrlW-1:0]   ctrl_bits, head;
  logic [NumOup-1:0]  head_sel;
  logic [IdxW-1:0]    head_idx;
  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [UsageW-1:0]  unused_usage;

  state_e             state_q;
  logic [NumOup-1:0]  pending_q, pending_d, cr_hs;
  logic [CrRespW-1:0] acc_q, acc_d;
  logic [IdxW-1:0]    idx_q;

  assign ctrl_bits    = ctrl_i;
  assign head_sel     = head[CtrlW-1:IdxW];
  assign head_idx     = head[IdxW-1:0];
  assign ctrl_ready_o = ~fifo_full;
  assign fifo_push    = ctrl_valid_i & ctrl_ready_o;
  assign fifo_pop     = (state_q == Idle) & ~fifo_empty;

  fifo_v3 #(
    .DATA_WIDTH (CtrlW),
    .DEPTH      (CtrlDepth)
  ) i_ctrl_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (unused_usage),
    .data_i  (ctrl_bits),
    .push_i  (fifo_push),
    .data_o  (head),
    .pop_i   (fifo_pop)
  );

  assign cr_readies_o = (state_q == Collect) ? pending_q : '0;
  assign cr_hs        = cr_valids_i & cr_readies_o;

  always_comb begin
    acc_d     = acc_q;
    pending_d = pending_q & ~cr_hs;
    for (int j = 0; j < NumOup; j++) begin
      if (cr_hs[j]) acc_d = acc_d | cr_resps_i[j];
    end
  end

  assign cr_valid_o = (state_q == Resp);
  assign cr_resp_o  = acc_q;
  assign cr_idx_o   = idx_q;

`ifdef ACE_CCU_SNOOP_RESP_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TimeoutCycles;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      pending_q <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
`ifdef ACE_CCU_SNOOP_RESP_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef ACE_CCU_SNOOP_RESP_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        Idle: begin
          if (!fifo_empty) begin
            pending_q <= head_sel;
            idx_q     <= head_idx;
            acc_q     <= '0;
`ifdef ACE_CCU_SNOOP_RESP_TIMEOUT_EN
            cnt_q     <= '0;
`endif
            state_q   <= (head_sel == '0) ? Resp : Collect;
          end
        end
        Collect: begin
          pending_q <= pending_d;
          acc_q     <= acc_d;
          if (pending_d == '0) begin
            state_q <= Resp;
          end
`ifdef ACE_CCU_SNOOP_RESP_TIMEOUT_EN
          else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
            // Give up on silent masters: flag Error so the initiator sees a failed snoop.
            pending_q <= '0;
            acc_q     <= acc_d | CrRespW'(1 << CrError);
            timeout_q <= 1'b1;
            state_q   <= Resp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        Resp: begin
          if (cr_ready_i) state_q <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

endmodule
